connect_n_engine: RTL
=====================

// Module: connect_n_engine
// PURPOSE
//   Parametrised Connect-N game engine: ROWS x COLS board, configurable win length.
//   Accepts column drops from the column-select input, stacks pieces with gravity and
//   alternates P1/P2 turns. Detects a win, a tie, or an illegal move.
//   Sits between the debounced column buttons/enable and the board display driver.
// PARAMETERS
//   ROWS     4  board height; row 0 is the bottom row
//   COLS     4  board width; cell index = row*COLS + col
//   WIN_LEN  4  pieces in a line that win; legal range 2..max(ROWS,COLS)
//   CW       $clog2(COLS)  derived localparam; width of column_calc
//   CELLS    ROWS*COLS     derived localparam
// PORTS
//   clk                input   1      system clock, rising edge
//   reset              input   1      asynchronous, active-high; clears board and game
//   enable             input   1      move request; rising edge sampled on clk
//   in_column          input   COLS   active-low one-hot column select (4'b1110 = col 0)
//   out_gameboard      output  CELLS  1 = cell occupied
//   out_players_cells  output  CELLS  owner of occupied cell: 0 = P1, 1 = P2; 0 if empty
//   out_game_status    output  2      00 playing, 01 P1 wins, 10 P2 wins, 11 tie
//   current_state      output  2      FSM state: 00 IDLE, 01 DROP, 10 CHECK, 11 DONE
//   playerTurn         output  1      player to move next: 0 = P1, 1 = P2
//   column_calc        output  CW     binary index of the last accepted column
//   move_rejected      output  1      one-cycle pulse on an illegal move request
// BEHAVIOUR
//   - Reset (async): all outputs 0; FSM in IDLE; P1 moves first; enable edge detector cleared.
//   - Enable edge: en_q <= enable each clk; a request is enable & ~en_q.
//     enable must be high across at least one rising edge; one move per high level.
//   - IDLE, on a request:
//       - Exactly one in_column bit low, and that column has an empty cell:
//         latch column_calc; go to DROP.
//       - Otherwise (zero or >1 bits low, or column full): move_rejected=1 for one cycle;
//         stay in IDLE; board and turn unchanged.
//   - DROP (1 cycle): set the lowest empty cell of the column in out_gameboard;
//     write playerTurn into out_players_cells at the same index; go to CHECK.
//   - CHECK (1 cycle): scan every horizontal, vertical, diagonal and anti-diagonal
//     window of WIN_LEN cells for the mover's pieces. Priority order:
//       - Win: status = 01 (P1) or 10 (P2); go to DONE; turn not toggled.
//       - Else board full: status = 11; go to DONE.
//       - Else toggle playerTurn; go to IDLE.
//   - Latency: request seen at edge k -> board updated at edge k+1 ->
//     status/turn updated at edge k+2. The next request is accepted at edge k+3 or later.
//   - Requests during DROP or CHECK are ignored (no reject pulse).
//   - DONE: every request gives a move_rejected pulse; the state is held until reset.
//   - Reset mid-DROP or mid-CHECK: the partial move is discarded; all outputs are 0
//     immediately.
//   - A win on the last empty cell reports the win, not a tie.
// CONFIGURATION
//   CONNECT_UNDO_EN defined:
//     - Adds input undo (1 bit, rising-edge detected like enable). The engine stores
//       the index of the last placed cell and a valid flag.
//     - Undo edge in IDLE or DONE with the flag set: clear that cell's occupancy and
//       owner bits; the mover becomes playerTurn again; status = 00; next state IDLE;
//       flag cleared. Single-level undo only.
//     - Undo with the flag clear: move_rejected pulse.
//     - Simultaneous undo and enable edges: undo wins; the enable edge is dropped silently.
//   CONNECT_UNDO_EN undefined: no undo port and no last-cell storage.
// TESTING
//   - Reset, in_column=4'b1110 with enable -> 2 clks later out_gameboard=16'h0001,
//     players_cells=0, playerTurn=1, status=00.
//   - Vertical win: cols 0,1,0,1,0,1,0 -> status=01, current_state=11; a further
//     request pulses move_rejected.
//   - Column full: five requests on col 3 (4'b0111) -> the 5th pulses move_rejected;
//     board and playerTurn unchanged.
//   - Illegal select: in_column=4'b1100 and then 4'b1111 -> move_rejected each time;
//     out_gameboard unchanged.
//   - Tie: cols 0,1,2,3,3,2,1,0,0,1,2,3,0,2,1,3 -> out_gameboard=16'hFFFF, status=11.
//   - Reset asserted 1 clk after a request -> out_gameboard=0, state=00,
//     playerTurn=0 with no clock edge.
//   - CONNECT_UNDO_EN: win by P1 on col 0, then undo -> status=00, state=00,
//     cell cleared, playerTurn=0; a second undo is rejected.

Source files
------------

// File: rtl/connect_n_engine.sv
// Connect-N game engine: ROWS x COLS board with gravity, alternating turns,
// win / tie / illegal-move detection. Optional single-level undo is built in
// when the CONNECT_UNDO_EN macro is defined.
module connect_n_engine #(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int WIN_LEN = 4,
    localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int CELLS  = ROWS * COLS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [COLS-1:0]  in_column,
`ifdef CONNECT_UNDO_EN
    input  logic             undo,
`endif
    output logic [CELLS-1:0] out_gameboard,
    output logic [CELLS-1:0] out_players_cells,
    output logic [1:0]       out_game_status,
    output logic [1:0]       current_state,
    output logic             playerTurn,
    output logic [CW-1:0]    column_calc,
    output logic             move_rejected
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_DROP  = 2'b01,
        S_CHECK = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t            state;
    logic              en_q;
    logic              req;
    logic [COLS-1:0]   sel;
    logic              one_hot;
    logic [CW-1:0]     sel_idx;
    logic [COLS-1:0]   top_row;
    logic              col_full;
    logic [CELLS-1:0]  drop_mask;
    logic [CELLS-1:0]  mine;
    logic [CELLS-1:0]  h_win, v_win, d_win, a_win;
    logic              win;

    assign current_state = state;
    assign req      = enable & ~en_q;
    assign sel      = ~in_column;
    assign one_hot  = (sel != '0) && ((sel & (sel - COLS'(1))) == '0);
    assign top_row  = out_gameboard[CELLS-1 -: COLS];
    assign col_full = top_row[sel_idx];
    assign mine     = out_gameboard & (playerTurn ? out_players_cells : ~out_players_cells);
    assign win      = |{h_win, v_win, d_win, a_win};

    // Binary index of the selected (active-low) column
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < COLS; i++) begin
            if (sel[i]) sel_idx = CW'(i);
        end
    end

    // Per-cell drop target and line windows anchored at each cell
    genvar gi, gk;
    generate
        for (gi = 0; gi < CELLS; gi++) begin : g_cell
            localparam int R = gi / COLS;
            localparam int C = gi % COLS;

            // Target is the empty cell of the chosen column resting on an occupied one
            if (R == 0) begin : g_bottom
                assign drop_mask[gi] = (column_calc == CW'(C)) & ~out_gameboard[gi];
            end else begin : g_upper
                assign drop_mask[gi] = (column_calc == CW'(C)) & ~out_gameboard[gi]
                                     & out_gameboard[gi-COLS];
            end

            if (C + WIN_LEN <= COLS) begin : g_h
                assign h_win[gi] = &mine[gi +: WIN_LEN];
            end else begin : g_nh
                assign h_win[gi] = 1'b0;
            end

            if (R + WIN_LEN <= ROWS) begin : g_v
                logic [WIN_LEN-1:0] bits;
                for (gk = 0; gk < WIN_LEN; gk++) begin : g_k
                    assign bits[gk] = mine[gi + gk*COLS];
                end
                assign v_win[gi] = &bits;
            end else begin : g_nv
                assign v_win[gi] = 1'b0;
            end

            if ((R + WIN_LEN <= ROWS) && (C + WIN_LEN <= COLS)) begin : g_d
                logic [WIN_LEN-1:0] bits;
                for (gk = 0; gk < WIN_LEN; gk++) begin : g_k
                    assign bits[gk] = mine[gi + gk*(COLS+1)];
                end
                assign d_win[gi] = &bits;
            end else begin : g_nd
                assign d_win[gi] = 1'b0;
            end

            if ((R + WIN_LEN <= ROWS) && (C >= WIN_LEN - 1)) begin : g_a
                logic [WIN_LEN-1:0] bits;
                for (gk = 0; gk < WIN_LEN; gk++) begin : g_k
                    assign bits[gk] = mine[gi + gk*(COLS-1)];
                end
                assign a_win[gi] = &bits;
            end else begin : g_na
                assign a_win[gi] = 1'b0;
            end
        end
    endgenerate

`ifdef CONNECT_UNDO_EN
    localparam int IW = (CELLS > 1) ? $clog2(CELLS) : 1;
    logic          undo_q;
    logic          undo_req;
    logic [IW-1:0] drop_idx;
    logic [IW-1:0] last_idx;
    logic          last_player;
    logic          last_valid;

    assign undo_req = undo & ~undo_q;

    // Encode the one-hot drop target so the last move can be reverted
    always_comb begin
        drop_idx = '0;
        for (int i = 0; i < CELLS; i++) begin
            if (drop_mask[i]) drop_idx = IW'(i);
        end
    end
`endif

    // Game FSM: request decode, gravity drop, win/tie evaluation, optional undo
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= S_IDLE;
            en_q              <= 1'b0;
            out_gameboard     <= '0;
            out_players_cells <= '0;
            out_game_status   <= 2'b00;
            playerTurn        <= 1'b0;
            column_calc       <= '0;
            move_rejected     <= 1'b0;
`ifdef CONNECT_UNDO_EN
            undo_q            <= 1'b0;
            last_idx          <= '0;
            last_player       <= 1'b0;
            last_valid        <= 1'b0;
`endif
        end else begin
            en_q          <= enable;
            move_rejected <= 1'b0;
`ifdef CONNECT_UNDO_EN
            undo_q        <= undo;
            if (undo_req && (state == S_IDLE || state == S_DONE)) begin
                if (last_valid) begin
                    out_gameboard[last_idx]     <= 1'b0;
                    out_players_cells[last_idx] <= 1'b0;
                    playerTurn                  <= last_player;
                    out_game_status             <= 2'b00;
                    state                       <= S_IDLE;
                    last_valid                  <= 1'b0;
                end else begin
                    move_rejected <= 1'b1;
                end
            end else
`endif
            begin
                case (state)
                    S_IDLE: begin
                        if (req) begin
                            if (one_hot && !col_full) begin
                                column_calc <= sel_idx;
                                state       <= S_DROP;
                            end else begin
                                move_rejected <= 1'b1;
                            end
                        end
                    end
                    S_DROP: begin
                        out_gameboard <= out_gameboard | drop_mask;
                        if (playerTurn) out_players_cells <= out_players_cells | drop_mask;
`ifdef CONNECT_UNDO_EN
                        last_idx    <= drop_idx;
                        last_player <= playerTurn;
                        last_valid  <= 1'b1;
`endif
                        state <= S_CHECK;
                    end
                    S_CHECK: begin
                        if (win) begin
                            out_game_status <= playerTurn ? 2'b10 : 2'b01;
                            state           <= S_DONE;
                        end else if (&out_gameboard) begin
                            out_game_status <= 2'b11;
                            state           <= S_DONE;
                        end else begin
                            playerTurn <= ~playerTurn;
                            state      <= S_IDLE;
                        end
                    end
                    S_DONE: begin
                        if (req) move_rejected <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
